// File: rtl/priority_grant_decoder.sv
// priority_grant_decoder
// Consumer side of a 4-channel priority encoder interface. Accepts an
// encoded request (V, Y), issues a registered one-hot grant, and holds it
// until the granted channel strobes done or TIMEOUT cycles elapse. A
// one-cycle RELEASE state separates consecutive grants.

module priority_grant_decoder #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       V,
    input  logic [1:0] Y,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    // Hold counter counts 0..TIMEOUT-1, so $clog2(TIMEOUT) bits always fit.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_grant;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_done_sel;
    logic             w_cnt_at_last;

    // Binary index to one-hot channel mask.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] m;
        m      = 4'b0000;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Only the granted channel's done strobe is meaningful.
    assign w_done_sel    = done[r_idx];
    assign w_cnt_at_last = (r_cnt == CNT_LAST);

    // State register; reset forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and next values of every registered output.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                if (V) begin
                    w_state_nxt = S_GRANT;
                    w_idx_nxt   = Y;
                    w_grant_nxt = onehot4(Y);
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_GRANT: begin
                // done takes precedence over timeout on the same edge.
                if (w_done_sel) begin
                    w_state_nxt = S_RELEASE;
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b1;
                end else if (w_cnt_at_last) begin
                    w_state_nxt   = S_RELEASE;
                    w_grant_nxt   = 4'b0000;
                    w_busy_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_RELEASE: begin
                // V is deliberately not sampled here to enforce the gap.
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Counter and output registers; reset clears them asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_grant   <= 4'b0000;
            r_idx     <= 2'b00;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

    // The grant vector must never have more than one bit set.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Testbench for priority_grant_decoder (TIMEOUT = 16).
module tb_priority_grant_decoder;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic       V;
    logic [1:0] Y;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;

    priority_grant_decoder #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .V         (V),
        .Y         (Y),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the resource, how many cycles it has been
    // visibly held, whether we are in the post-release gap cycle.
    int owner;   // -1 when nobody holds a grant
    int held;    // cycles the current grant has been visible
    bit cool;    // gap cycle after a release
    bit m_to;    // timeout pulse currently shown
    int last;    // most recent granted index

    task automatic model_reset();
        owner = -1; held = 0; cool = 1'b0; m_to = 1'b0; last = 0;
    endtask

    task automatic model_edge();
        bit to_now;
        to_now = 1'b0;
        if (owner >= 0) begin
            if (done[owner]) begin
                owner = -1; cool = 1'b1;
            end else if (held == TIMEOUT) begin
                owner = -1; cool = 1'b1; to_now = 1'b1;
            end else begin
                held++;
            end
        end else if (cool) begin
            cool = 1'b0;
        end else if (V) begin
            owner = int'(Y); held = 1; last = int'(Y);
        end
        m_to = to_now;
    endtask

    function automatic logic [7:0] model_exp();
        logic [3:0] g;
        g = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
        return {g, 2'(last), (owner >= 0) || cool, m_to};
    endfunction

    function automatic logic [7:0] dut_obs();
        return {grant, grant_idx, busy, timeout};
    endfunction

    // Compares {grant, grant_idx, busy, timeout}.
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got grant/idx/busy/to=%b_%b_%b_%b required %b_%b_%b_%b",
                     name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [1:0] y;
        logic [3:0] d;
        logic [3:0] eg;
        logic [1:0] ei;
        logic       eb;
        logic       et;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Decode, ignored Y change, wrong-channel done, release, gap with V
        // held, done in RELEASE/IDLE ignored, done high on first GRANT edge.
        tbl[0]  = '{1'b1, 2'd2, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 2'd3, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 2'd3, 4'b0001, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'd1, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'd1, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'd2, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'd0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        rst = 1'b1; V = 1'b0; Y = 2'd0; done = 4'b0000;
        model_reset();
        #22;
        chk("reset_state", dut_obs(), 8'b0000_00_0_0);
        rst = 1'b0;
        #1;

        // Table-driven vectors, each applied for one edge.
        for (int i = 0; i < 12; i++) begin
            V = tbl[i].v; Y = tbl[i].y; done = tbl[i].d;
            step();
            chk($sformatf("table_%0d", i), dut_obs(),
                {tbl[i].eg, tbl[i].ei, tbl[i].eb, tbl[i].et});
        end

        // Timeout: grant visible for exactly TIMEOUT cycles, then a pulse.
        V = 1'b1; Y = 2'd3; done = 4'b0000;
        step();
        chk("timeout_first", dut_obs(), 8'b1000_11_1_0);
        V = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            chk($sformatf("timeout_hold_%0d", i), dut_obs(), 8'b1000_11_1_0);
        end
        step();
        chk("timeout_pulse", dut_obs(), 8'b0000_11_1_1);
        step();
        chk("timeout_idle", dut_obs(), 8'b0000_11_0_0);

        // done on the same edge as the timeout condition: done wins.
        V = 1'b1; Y = 2'd2;
        step();
        chk("simul_grant", dut_obs(), 8'b0100_10_1_0);
        V = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) step();
        chk("simul_last_cycle", dut_obs(), 8'b0100_10_1_0);
        done = 4'b0100;
        step();
        chk("simul_done_wins", dut_obs(), 8'b0000_10_1_0);
        done = 4'b0000;
        step();
        chk("simul_idle", dut_obs(), 8'b0000_10_0_0);

        // Asynchronous reset in the middle of a grant.
        V = 1'b1; Y = 2'd0;
        step();
        chk("rst_grant_on", dut_obs(), 8'b0001_00_1_0);
        V = 1'b0;
        #2;
        async_reset();
        chk("rst_async_drop", dut_obs(), 8'b0000_00_0_0);
        rst = 1'b0;
        step();
        chk("rst_after_idle", dut_obs(), 8'b0000_00_0_0);
        step();
        chk("rst_after_idle2", dut_obs(), 8'b0000_00_0_0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            V = ($urandom_range(0, 9) < 7);
            Y = 2'($urandom);
            if (((i / 400) % 2) == 1)
                done = 4'b0000 | {3'b000, ($urandom_range(0, 39) == 0)};
            else
                done = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            step();
            chk($sformatf("rand_%0d", i), dut_obs(), model_exp());
            chk($sformatf("rand_onehot_%0d", i), {7'd0, $onehot0(grant)}, 8'd1);
            if ($urandom_range(0, 249) == 0) begin
                #2;
                async_reset();
                chk($sformatf("rand_rst_%0d", i), dut_obs(), 8'b0000_00_0_0);
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/priority_grant_decoder.md
Name: priority_grant_decoder

Overview:
- Consumer side of the 4-bit priority encoder interface.
- Takes the encoded request index Y[1:0] and valid flag V, decodes it to a registered one-hot grant, and holds that grant until the granted channel signals done or a timeout expires.
- Sits between the request priority encoder and four shared-resource clients.
- Enforces one grant at a time, with a mandatory one-cycle release gap between grants.

Parameters:
- TIMEOUT, 16: maximum number of cycles a grant may be held without done. Legal range is 2 to 256. The counter width is $clog2(TIMEOUT).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- V  input  1  encoded request valid, from the encoder
- Y  input  2  encoded request index, from the encoder (3 = highest priority)
- done  input  4  per-channel release strobe, level-sampled on each clk edge
- grant  output  4  registered one-hot grant; 0000 when no grant is active
- grant_idx  output  2  index of the current or most recent grant
- busy  output  1  high in GRANT and RELEASE states
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst=1: state=IDLE, counter=0, grant=0000, grant_idx=00, busy=0, timeout=0. These outputs take effect immediately, without waiting for a clk edge.
- Reset asserted mid-grant drops grant asynchronously. No timeout pulse is generated.
- All outputs are registered; none depend combinationally on V, Y or done.

State machine:
- IDLE: grant=0000, busy=0.
  - On a clk edge with V=1: latch Y into grant_idx, set grant=one-hot(Y) (bit Y set), clear counter, go to GRANT.
  - Latency from V sampled to grant visible is 1 cycle.
  - V=0 stays in IDLE. Y is ignored when V=0.
- GRANT: grant and grant_idx are held constant. V and Y are ignored, so changes to them have no effect.
  - On each edge, if done[grant_idx]=1: go to RELEASE.
  - Else if counter==TIMEOUT-1: go to RELEASE and assert timeout for the RELEASE cycle.
  - Else: counter increments by 1.
  - Without done, grant is high for exactly TIMEOUT cycles.
  - done bits other than done[grant_idx] are ignored.
- RELEASE: lasts exactly one cycle. grant=0000, busy=1, grant_idx holds its value. Next state is IDLE unconditionally.
  - V is not sampled in RELEASE. A request held high through RELEASE is accepted on the first IDLE edge, which gives a minimum 2-cycle gap between grants.

Boundary conditions:
- done[grant_idx] and the timeout condition on the same edge: done wins, and timeout stays 0.
- done[grant_idx] already high on the first GRANT edge: releases after exactly 1 grant cycle.
- done asserted while in IDLE or RELEASE: ignored.
- Counter never wraps, because the transition out of GRANT occurs at TIMEOUT-1.
- grant is always either 0000 or exactly one bit set. A simulation assertion checks this one-hot property.

Test Plan:
- Reset: rst=1 mid-simulation with no clk edge -> grant=0000, grant_idx=00, busy=0, timeout=0 immediately.
- Decode: in IDLE drive V=1, Y=10 -> one edge later grant=0100, grant_idx=10, busy=1; then change Y to 11 during GRANT -> grant stays 0100.
- Release/gap: with grant=0100, assert done=0100 for one cycle -> next cycle grant=0000, busy=1; following cycle busy=0. With V=1, Y=01 held throughout -> grant=0010 one edge after returning to IDLE.
- Timeout: TIMEOUT=16, V=1, Y=11, done=0000 -> grant=1000 for exactly 16 cycles, then grant=0000 with a 1-cycle timeout=1, then IDLE.
- Wrong-channel/simultaneous: with grant=0100, drive done=0001 -> no effect. Drive done=0100 on the edge where counter==15 -> release occurs, timeout=0.
- Reset mid-grant: grant=0001 active, pulse rst between edges -> grant=0000 asynchronously. After rst deasserts with V=0 -> remains IDLE, busy=0.
